// File: rtl/pending_instr_tracker.sv
// pending_instr_tracker
//
// Per-warp in-flight instruction tracker for the warp scheduler. It sits directly
// downstream of the commit stage's registered committed_warps pulse. It keeps one
// saturating counter per warp: issued instructions increment it and committed
// instructions decrement it. From those counters it derives busy and full status
// for issue throttling, and it services one single-warp drain request at a time.
// Drain requests are used by fences, barriers and wspawn/tmc.
//
// Ports
//   clk               clock
//   reset             synchronous, active-high
//   issue_fire        one instruction (eop) issued this cycle
//   issue_wid         warp of the issued instruction
//   committed_warps   bit w = one instruction of warp w committed this cycle
//   pending_warps     bit w = warp w has instructions in flight
//   full_warps        bit w = warp w counter at maximum (do not issue to it)
//   all_idle          no warp has instructions in flight
//   drain_valid       drain request; held stable until drain_ready
//   drain_wid         warp to drain
//   drain_ready       one-cycle pulse: drain accepted and complete
//   err_overflow      sticky: issue to a warp whose counter was already full
//   err_underflow     sticky: commit to a warp whose counter was already zero
//   perf_busy_cycles  (only with PENDING_INSTR_PERF_EN) free-running 64-bit count
//                     of cycles in which any warp had work in flight
//
// Build option
//   PENDING_INSTR_PERF_EN  when defined, adds the perf_busy_cycles port and counter.

module pending_instr_tracker #(
  parameter int NUM_WARPS = 4,
  parameter int CTR_W     = 4,
  parameter int NW_W      = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_fire,
  input  logic [NW_W-1:0]      issue_wid,
  input  logic [NUM_WARPS-1:0] committed_warps,
  output logic [NUM_WARPS-1:0] pending_warps,
  output logic [NUM_WARPS-1:0] full_warps,
  output logic                 all_idle,
  input  logic                 drain_valid,
  input  logic [NW_W-1:0]      drain_wid,
  output logic                 drain_ready,
  output logic                 err_overflow,
  output logic                 err_underflow
`ifdef PENDING_INSTR_PERF_EN
  ,
  output logic [63:0]          perf_busy_cycles
`endif
);

  localparam logic [CTR_W-1:0] CNT_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CNT_ZERO = '0;

  // Saturating up/down step for one counter. The result is packed as
  // {overflow, underflow, next_count}. Simultaneous inc and dec cancel.
  function automatic logic [CTR_W+1:0] sat_step(
    input logic [CTR_W-1:0] cur,
    input logic             inc,
    input logic             dec
  );
    logic             ovf;
    logic             udf;
    logic [CTR_W-1:0] nxt;
    ovf = 1'b0;
    udf = 1'b0;
    nxt = cur;
    if (inc && !dec) begin
      if (cur == CNT_MAX) ovf = 1'b1;
      else                nxt = cur + CTR_W'(1);
    end else if (dec && !inc) begin
      if (cur == CNT_ZERO) udf = 1'b1;
      else                 nxt = cur - CTR_W'(1);
    end
    return {ovf, udf, nxt};
  endfunction

  logic [CTR_W-1:0]     count     [NUM_WARPS];
  logic [CTR_W-1:0]     count_nxt [NUM_WARPS];
  logic [NUM_WARPS-1:0] inc_vec;
  logic [NUM_WARPS-1:0] ovf_vec;
  logic [NUM_WARPS-1:0] udf_vec;

  // ---- stage p0: decode issue into a per-warp increment vector ----
  always_comb begin
    inc_vec = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      inc_vec[w] = issue_fire && (issue_wid == NW_W'(w));
    end
  end

  always_comb begin
    ovf_vec = '0;
    udf_vec = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      count_nxt[w] = count[w];
      {ovf_vec[w], udf_vec[w], count_nxt[w]} =
        sat_step(count[w], inc_vec[w], committed_warps[w]);
    end
  end

  // ---- stage p1: counter and sticky error registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        count[w] <= '0;
      end
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        count[w] <= count_nxt[w];
      end
      if (|ovf_vec) err_overflow  <= 1'b1;
      if (|udf_vec) err_underflow <= 1'b1;
    end
  end

  // Status comes from the registered counts only. A warp that becomes full
  // this cycle is flagged next cycle; the scheduler throttles from that.
  always_comb begin
    pending_warps = '0;
    full_warps    = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      pending_warps[w] = (count[w] != CNT_ZERO);
      full_warps[w]    = (count[w] == CNT_MAX);
    end
  end

  assign all_idle = ~|pending_warps;

  // ---- drain FSM ----
  typedef enum logic [1:0] {
    DRAIN_IDLE = 2'd0,
    DRAIN_WAIT = 2'd1,
    DRAIN_DONE = 2'd2
  } drain_state_t;

  drain_state_t    drain_state;
  drain_state_t    drain_state_nxt;
  logic [NW_W-1:0] drain_wid_r;
  logic            drain_target_idle;

  assign drain_target_idle = (count[drain_wid_r] == CNT_ZERO);

  always_ff @(posedge clk) begin
    if (reset) drain_state <= DRAIN_IDLE;
    else       drain_state <= drain_state_nxt;
  end

  // The target warp is captured on acceptance. It is qualified by drain_state,
  // so it needs no reset.
  always_ff @(posedge clk) begin
    if (drain_state == DRAIN_IDLE && drain_valid) drain_wid_r <= drain_wid;
  end

  // Every request spends at least one cycle in WAIT, even when the warp is already
  // idle, so the earliest drain_ready is two cycles after the request. If the
  // requester drops drain_valid during WAIT, the FSM abandons the drain silently.
  always_comb begin
    drain_state_nxt = drain_state;
    drain_ready     = 1'b0;
    case (drain_state)
      DRAIN_IDLE: begin
        if (drain_valid) drain_state_nxt = DRAIN_WAIT;
      end
      DRAIN_WAIT: begin
        if (!drain_valid)           drain_state_nxt = DRAIN_IDLE;
        else if (drain_target_idle) drain_state_nxt = DRAIN_DONE;
      end
      DRAIN_DONE: begin
        drain_ready     = 1'b1;
        drain_state_nxt = DRAIN_IDLE;
      end
      default: drain_state_nxt = DRAIN_IDLE;
    endcase
  end

`ifdef PENDING_INSTR_PERF_EN
  // ---- perf: busy-cycle counter, wraps at 2^64 ----
  always_ff @(posedge clk) begin
    if (reset)          perf_busy_cycles <= '0;
    else if (!all_idle) perf_busy_cycles <= perf_busy_cycles + 64'd1;
  end
`endif

endmodule
